// File: rtl/mcu_read_sched.sv
// MCU row-read scheduler: walks a frame band by band and issues one 8-pixel block row per cycle
// in MCU order, paced by band-buffer credits granted by the writer.
module mcu_read_sched #(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    localparam int XW = $clog2(SENSOR_X_SIZE),
    localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [XW-1:0] x_size_m1,
    input  logic [YW-1:0] y_size_m1,
    input  logic          band_ready,
    input  logic          rd_hold,
    output logic          rd_valid,
    output logic          rd_luma,
    output logic [1:0]    rd_comp,
    output logic [XW-1:0] rd_x,
    output logic [3:0]    rd_line,
    output logic          rd_buf,
    output logic [2:0]    rd_row,
    output logic          gray_out,
    output logic          band_done,
    output logic          frame_done,
    output logic          ovf_err
);

    localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_BAND = 2'd1, ST_READ = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [XW-1:0]   xsz_q, xsz_d;
    logic [YW-1:0]   ysz_q, ysz_d;
    logic [1:0]      credits_q, credits_d;
    logic [YW-1:0]   band_q, band_d;
    logic [XW-1:0]   mcu_q, mcu_d;
    logic [2:0]      blk_q, blk_d;
    logic [2:0]      row_q, row_d;
    logic            buf_q, buf_d;
    logic            ovf_q, ovf_d;
    logic            band_done_q, band_done_d;
    logic            frame_done_q, frame_done_d;

    logic [2:0]      last_blk_s, n_luma_s;
    logic [XW-1:0]   last_mcu_s, mcu_x_s, x_s;
    logic [YW-1:0]   last_band_s, last_line_s;
    logic [YW+3:0]   band_base_s, abs_line_s;
    logic [3:0]      raw_line_s, line_s;
    logic [1:0]      comp_s;
    logic            wide_s, tall_s, luma_s, xsub_s, ysub_s, comp_tall_s, gray_s;
    logic            in_read_s, band_end_s;

    // Frame geometry from the latched mode and size
    always_comb begin
        case (mode_q)
            2'd0:    begin last_blk_s = 3'd5; n_luma_s = 3'd4; end
            2'd1:    begin last_blk_s = 3'd3; n_luma_s = 3'd2; end
            2'd2:    begin last_blk_s = 3'd2; n_luma_s = 3'd1; end
            default: begin last_blk_s = 3'd0; n_luma_s = 3'd1; end
        endcase
        wide_s      = ~mode_q[1];
        tall_s      = (mode_q == 2'd0);
        last_mcu_s  = wide_s ? (xsz_q >> 4) : (xsz_q >> 3);
        last_band_s = tall_s ? (ysz_q >> 4) : (ysz_q >> 3);
    end

    // Current block decode, pixel position and bottom-edge line clamp
    always_comb begin
        luma_s      = (blk_q < n_luma_s);
        comp_s      = luma_s ? 2'd0 : 2'(blk_q - n_luma_s + 3'd1);
        xsub_s      = luma_s & wide_s & blk_q[0];
        ysub_s      = luma_s & tall_s & blk_q[1];
        mcu_x_s     = wide_s ? (mcu_q << 4) : (mcu_q << 3);
        x_s         = luma_s ? (mcu_x_s + {{(XW-4){1'b0}}, xsub_s, 3'b000}) : (mcu_q << 3);
        raw_line_s  = {ysub_s, row_q};
        // Mode-0 chroma is vertically halved: 8-line bands against half the image height
        comp_tall_s = luma_s & tall_s;
        last_line_s = (~luma_s & tall_s) ? (ysz_q >> 1) : ysz_q;
        band_base_s = comp_tall_s ? {band_q, 4'b0000} : {1'b0, band_q, 3'b000};
        abs_line_s  = band_base_s + {{YW{1'b0}}, raw_line_s};
        if (abs_line_s > {4'b0000, last_line_s}) begin
            line_s = comp_tall_s ? last_line_s[3:0] : {1'b0, last_line_s[2:0]};
        end else begin
            line_s = raw_line_s;
        end
        gray_s = luma_s & (x_s > xsz_q);
    end

    assign in_read_s  = (state_q == ST_READ);
    assign rd_valid   = in_read_s & ~rd_hold;
    assign rd_luma    = in_read_s & luma_s;
    assign rd_comp    = in_read_s ? comp_s : 2'd0;
    assign rd_x       = in_read_s ? x_s : {XW{1'b0}};
    assign rd_line    = in_read_s ? line_s : 4'd0;
    assign rd_row     = in_read_s ? row_q : 3'd0;
    assign gray_out   = in_read_s & gray_s;
    assign rd_buf     = buf_q;
    assign band_done  = band_done_q;
    assign frame_done = frame_done_q;
    assign ovf_err    = ovf_q;

    // Next-state: sequencing counters, credits and band/frame completion
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        xsz_d        = xsz_q;
        ysz_d        = ysz_q;
        band_d       = band_q;
        mcu_d        = mcu_q;
        blk_d        = blk_q;
        row_d        = row_q;
        buf_d        = buf_q;
        credits_d    = credits_q;
        ovf_d        = ovf_q;
        band_done_d  = 1'b0;
        frame_done_d = 1'b0;
        band_end_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    xsz_d   = x_size_m1;
                    ysz_d   = y_size_m1;
                    band_d  = {YW{1'b0}};
                    mcu_d   = {XW{1'b0}};
                    blk_d   = 3'd0;
                    row_d   = 3'd0;
                    state_d = ST_WAIT_BAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BAND: begin
                if (credits_q != 2'd0) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WAIT_BAND;
                end
            end
            ST_READ: begin
                if (!rd_hold) begin
                    row_d = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        if (blk_q == last_blk_s) begin
                            blk_d = 3'd0;
                            if (mcu_q == last_mcu_s) begin
                                mcu_d      = {XW{1'b0}};
                                band_end_s = 1'b1;
                            end else begin
                                mcu_d = mcu_q + X_ONE;
                            end
                        end else begin
                            blk_d = blk_q + 3'd1;
                        end
                    end else begin
                        blk_d = blk_q;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A grant arriving on the release edge cancels out; a grant beyond two is dropped
        if (band_ready && !band_end_s) begin
            if (credits_q == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + 2'd1;
            end
        end else if (!band_ready && band_end_s) begin
            credits_d = credits_q - 2'd1;
        end else begin
            credits_d = credits_q;
        end

        if (band_end_s) begin
            buf_d       = ~buf_q;
            band_done_d = 1'b1;
            if (band_q == last_band_s) begin
                frame_done_d = 1'b1;
                band_d       = {YW{1'b0}};
                state_d      = ST_IDLE;
            end else begin
                band_d  = band_q + Y_ONE;
                state_d = (credits_d != 2'd0) ? ST_READ : ST_WAIT_BAND;
            end
        end else begin
            band_done_d = 1'b0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            xsz_q        <= {XW{1'b0}};
            ysz_q        <= {YW{1'b0}};
            credits_q    <= 2'd0;
            band_q       <= {YW{1'b0}};
            mcu_q        <= {XW{1'b0}};
            blk_q        <= 3'd0;
            row_q        <= 3'd0;
            buf_q        <= 1'b0;
            ovf_q        <= 1'b0;
            band_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            xsz_q        <= xsz_d;
            ysz_q        <= ysz_d;
            credits_q    <= credits_d;
            band_q       <= band_d;
            mcu_q        <= mcu_d;
            blk_q        <= blk_d;
            row_q        <= row_d;
            buf_q        <= buf_d;
            ovf_q        <= ovf_d;
            band_done_q  <= band_done_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_mcu_read_sched.sv
// Scoreboard bench for mcu_read_sched: a loop-nest frame model queues every expected row read and
// band release; a negedge monitor pops and compares as the scheduler presents them.
module tb_mcu_read_sched;

    localparam int XW = 10;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          resetn, start, band_ready, rd_hold;
    logic [1:0]    mode;
    logic [XW-1:0] x_size_m1;
    logic [YW-1:0] y_size_m1;
    logic          rd_valid, rd_luma, rd_buf, gray_out, band_done, frame_done, ovf_err;
    logic [1:0]    rd_comp;
    logic [XW-1:0] rd_x;
    logic [3:0]    rd_line;
    logic [2:0]    rd_row;

    mcu_read_sched dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode),
        .x_size_m1(x_size_m1), .y_size_m1(y_size_m1), .band_ready(band_ready),
        .rd_hold(rd_hold), .rd_valid(rd_valid), .rd_luma(rd_luma), .rd_comp(rd_comp),
        .rd_x(rd_x), .rd_line(rd_line), .rd_buf(rd_buf), .rd_row(rd_row),
        .gray_out(gray_out), .band_done(band_done), .frame_done(frame_done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = row read, 1 = band release
        int luma; int comp; int x; int line; int bufv; int row; int gray; int fdone;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_buf = 0;
    int   bands_seen = 0;
    int   valid_cnt = 0;
    bit   frame_seen = 1'b0;

    function automatic logic [31:0] pack_row(int bufv, int luma, int comp, int x, int line,
                                             int row, int gray);
        return {4'b0000, bufv[0], gray[0], luma[0], comp[1:0], row[2:0], line[3:0], x[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: every read of a frame in band / MCU / block / row order
    task automatic push_frame(input int md, input int xm1, input int ym1);
        int mw, bh, nblk, nluma, nbands, nmcu, x, ysub, cbh, last, line;
        exp_t e;
        mw    = (md < 2) ? 16 : 8;
        bh    = (md == 0) ? 16 : 8;
        nblk  = (md == 0) ? 6 : (md == 1) ? 4 : (md == 2) ? 3 : 1;
        nluma = (md == 0) ? 4 : (md == 1) ? 2 : 1;
        nbands = ym1 / bh + 1;
        nmcu   = xm1 / mw + 1;
        for (int b = 0; b < nbands; b++) begin
            for (int m = 0; m < nmcu; m++) begin
                for (int k = 0; k < nblk; k++) begin
                    e = '{default: 0};
                    e.luma = (k < nluma) ? 1 : 0;
                    e.comp = e.luma ? 0 : k - nluma + 1;
                    if (e.luma != 0) begin
                        x    = m * mw + ((md < 2) ? (k % 2) * 8 : 0);
                        ysub = (md == 0) ? k / 2 : 0;
                        cbh  = bh;
                        last = ym1;
                    end else begin
                        x    = m * 8;
                        ysub = 0;
                        cbh  = 8;
                        last = (md == 0) ? ym1 / 2 : ym1;
                    end
                    for (int r = 0; r < 8; r++) begin
                        line = ysub * 8 + r;
                        if (b * cbh + line > last) line = last % cbh;
                        e.x = x; e.line = line; e.row = r; e.bufv = model_buf;
                        e.gray = (e.luma != 0 && x > xm1) ? 1 : 0;
                        exp_q.push_back(e);
                    end
                end
            end
            model_buf = 1 - model_buf;
            e = '{default: 0};
            e.kind = 1; e.bufv = model_buf; e.fdone = (b == nbands - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare presented reads, held outputs and release pulses against the queue
    always @(negedge clk) begin
        if (resetn) begin
            if (band_done) begin
                bands_seen++;
                if (frame_done) frame_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_band_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("band_done_kind", mon_e.kind, 32'd1);
                    check("band_done_flags", {frame_done, rd_buf}, {mon_e.fdone[0], mon_e.bufv[0]});
                end
            end else if (frame_done) begin
                check("frame_done_alone", 32'd1, 32'd0);
            end
            if (rd_valid) begin
                valid_cnt++;
                check("valid_under_hold", rd_hold, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("row_kind", mon_e.kind, 32'd0);
                    check("row_fields", pack_row(rd_buf, rd_luma, rd_comp, rd_x, rd_line, rd_row, gray_out),
                          pack_row(mon_e.bufv, mon_e.luma, mon_e.comp, mon_e.x, mon_e.line, mon_e.row, mon_e.gray));
                end
            end else if (rd_hold && (rd_luma || rd_comp != 2'd0)) begin
                if (exp_q.size() == 0) begin
                    check("held_without_pending", 32'd1, 32'd0);
                end else begin
                    check("held_outputs", pack_row(rd_buf, rd_luma, rd_comp, rd_x, rd_line, rd_row, gray_out),
                          pack_row(exp_q[0].bufv, exp_q[0].luma, exp_q[0].comp, exp_q[0].x,
                                   exp_q[0].line, exp_q[0].row, exp_q[0].gray));
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {rd_valid, rd_luma, rd_comp, rd_x, rd_line, rd_row, gray_out, rd_buf,
                     band_done, frame_done, ovf_err}, 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        exp_q.delete();
        model_buf = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic issue_start(input int md, input int xm1, input int ym1);
        @(posedge clk); #1;
        mode = md[1:0]; x_size_m1 = xm1[XW-1:0]; y_size_m1 = ym1[YW-1:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int md, input int xm1, input int ym1, input int hold_pct,
                             input int rdy_pct, input bit spurious);
        int nbands, given, base, cyc;
        nbands = ym1 / ((md == 0) ? 16 : 8) + 1;
        push_frame(md, xm1, ym1);
        frame_seen = 1'b0;
        base  = bands_seen;
        given = 0;
        cyc   = 0;
        issue_start(md, xm1, ym1);
        while (!frame_seen && cyc < 6000) begin
            rd_hold    = ($urandom_range(99) < hold_pct);
            band_ready = 1'b0;
            if (given < nbands && (given - (bands_seen - base)) < 2 && $urandom_range(99) < rdy_pct) begin
                band_ready = 1'b1;
                given++;
            end
            if (spurious) begin
                mode      = 2'($urandom_range(3));
                x_size_m1 = XW'($urandom_range(63));
                y_size_m1 = YW'($urandom_range(63));
                start     = ((bands_seen - base) <= nbands - 2) && ($urandom_range(9) == 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        band_ready = 1'b0; rd_hold = 1'b0; start = 1'b0;
        check("frame_timeout", frame_seen, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("no_overflow", ovf_err, 32'd0);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 band_ready = 1'b1;
        @(posedge clk); #1 band_ready = 1'b0;
    endtask

    initial begin
        int cyc, v0;
        resetn = 1'b1; start = 1'b0; mode = 2'd0; x_size_m1 = '0; y_size_m1 = '0;
        band_ready = 1'b0; rd_hold = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("initial_reset");
        resetn = 1'b1;

        // 32x16 4:2:0 single band: 96 reads, joint band/frame release
        valid_cnt = 0;
        run_frame(0, 31, 15, 0, 100, 1'b0);
        check("rows_32x16", valid_cnt, 32'd96);
        check("buf_after_band", rd_buf, 32'd1);

        run_frame(0, 19, 15, 0, 50, 1'b0);   // right-edge gray blocks
        run_frame(2, 7, 11, 0, 50, 1'b0);    // bottom clamp in band 1
        run_frame(1, 40, 20, 0, 60, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_frame($urandom_range(3), $urandom_range(47), $urandom_range(35), 40, 30, 1'b1);
        end

        // Credit saturation from idle
        pulse_ready();
        pulse_ready();
        check("ovf_two_credits", ovf_err, 32'd0);
        pulse_ready();
        check("ovf_third_credit", ovf_err, 32'd1);
        apply_reset();
        check("ovf_cleared", ovf_err, 32'd0);

        // Grant coincident with a release leaves credits at two
        pulse_ready();
        pulse_ready();
        push_frame(3, 7, 15);
        frame_seen = 1'b0;
        issue_start(3, 7, 15);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(rd_valid && rd_row == 3'd7) && cyc < 100);
        check("coincide_wait_timeout", (cyc < 100), 32'd1);
        band_ready = 1'b1;
        @(posedge clk); #1 band_ready = 1'b0;
        @(posedge clk); #1 band_ready = 1'b1;
        @(posedge clk); #1 band_ready = 1'b0;
        check("ovf_after_coincide", ovf_err, 32'd1);
        cyc = 0;
        while (!frame_seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("coincide_frame_timeout", frame_seen, 32'd1);
        check("coincide_queue", exp_q.size(), 32'd0);

        // Reset in the middle of a band abandons the frame
        apply_reset();
        push_frame(0, 31, 31);
        frame_seen = 1'b0;
        issue_start(0, 31, 31);
        pulse_ready();
        v0  = valid_cnt;
        cyc = 0;
        while (valid_cnt - v0 < 20 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midband_wait_timeout", (cyc < 200), 32'd1);
        apply_reset();
        repeat (30) @(posedge clk);
        #1;
        check("no_release_after_reset", frame_seen, 32'd0);
        run_frame(3, 15, 7, 20, 50, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
